// File: rtl/fp_norm_pkg.sv
// Shared types and sizing helpers for the post-add normaliser.
package fp_norm_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MANT_W = 28;

    typedef enum logic [1:0] {
        NORM_CARRY,
        NORM_LEFT,
        NORM_DENORM,
        NORM_ZERO
    } norm_class_e;

    // Width of a leading-zero count over the MANT_W-1 bits below the carry.
    function automatic int lzc_w(input int mant_w);
        return $clog2(mant_w) + 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    logic found;

    // Scan from the MSB down and latch the position of the first set bit.
    always_comb begin
        cnt   = CNT_W'(WIDTH);
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && din[WIDTH-1-i]) begin
                cnt   = CNT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-add normaliser: stage 1 classifies the raw sum, stage 2
// applies the shift and exponent adjustment. Valid/ready on both sides.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W,
    parameter int TAG_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_underflow,
    output logic              o_overflow,
    output logic              o_zero
);

    localparam int LZW   = lzc_w(MANT_W);
    localparam int CMP_W = ((EXP_W > LZW) ? EXP_W : LZW) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] EXP_MAXM1 = EXP_MAX - 1'b1;

    logic adv1, adv2;
    logic [LZW-1:0] lzc_n;
    norm_class_e    cls;

    logic              v1;
    norm_class_e       s1_class;
    logic [LZW-1:0]    s1_n;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_sign;
    logic [TAG_W-1:0]  s1_tag;

    logic [EXP_W-1:0]  nx_exp;
    logic [MANT_W-1:0] nx_mant;
    logic [EXP_W-1:0]  dn_shift;
    logic              nx_uf, nx_of, nx_zero;

    assign adv2    = ~o_valid | i_ready;
    assign adv1    = ~v1 | adv2;
    assign o_ready = adv1;

    fp_lzc #(
        .WIDTH (MANT_W - 1),
        .CNT_W (LZW)
    ) u_lzc (
        .din (i_mant[MANT_W-2:0]),
        .cnt (lzc_n)
    );

    // Classify the incoming sum; carry outranks zero, which outranks a left shift.
    always_comb begin
        cls = NORM_DENORM;
        if (i_mant[MANT_W-1])
            cls = NORM_CARRY;
        else if (i_mant == '0)
            cls = NORM_ZERO;
        else if (CMP_W'(lzc_n) < CMP_W'(i_exp))
            cls = NORM_LEFT;
    end

    // Stage 1 register: loads only when the pipe can advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1       <= 1'b0;
            s1_class <= NORM_ZERO;
            s1_n     <= '0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_sign  <= 1'b0;
            s1_tag   <= '0;
        end else if (adv1) begin
            v1 <= i_valid;
            if (i_valid) begin
                s1_class <= cls;
                s1_n     <= lzc_n;
                s1_exp   <= i_exp;
                s1_mant  <= i_mant;
                s1_sign  <= i_sign;
                s1_tag   <= i_tag;
            end
        end
    end

    // Apply the shift and exponent adjustment selected by the stage-1 class.
    always_comb begin
        nx_exp   = '0;
        nx_mant  = '0;
        nx_uf    = 1'b0;
        nx_of    = 1'b0;
        nx_zero  = 1'b0;
        dn_shift = '0;
        unique case (s1_class)
            NORM_CARRY: begin
                if (s1_exp >= EXP_MAXM1) begin
                    nx_exp = EXP_MAX;
                    nx_of  = 1'b1;
                end else begin
                    nx_exp  = s1_exp + 1'b1;
                    // Shift right by one, folding the two dropped bits into sticky.
                    nx_mant = {1'b0, s1_mant[MANT_W-1:2], s1_mant[1] | s1_mant[0]};
                end
            end
            NORM_LEFT: begin
                nx_mant = s1_mant << s1_n;
                nx_exp  = s1_exp - EXP_W'(s1_n);
            end
            NORM_DENORM: begin
                dn_shift = (s1_exp == '0) ? '0 : s1_exp - 1'b1;
                nx_mant  = s1_mant << dn_shift;
                nx_uf    = 1'b1;
            end
            NORM_ZERO: begin
                nx_zero = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage 2 / output register: holds while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_sign      <= 1'b0;
            o_exp       <= '0;
            o_mant      <= '0;
            o_tag       <= '0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
            o_zero      <= 1'b0;
        end else if (adv2) begin
            o_valid <= v1;
            if (v1) begin
                o_sign      <= s1_sign;
                o_exp       <= nx_exp;
                o_mant      <= nx_mant;
                o_tag       <= s1_tag;
                o_underflow <= nx_uf;
                o_overflow  <= nx_of;
                o_zero      <= nx_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed bench for fp_norm_pipe: vector table, backpressure and reset sequences.
module tb_fp_norm_pipe;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [27:0] i_mant;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic        o_sign;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic [3:0]  o_tag;
    logic        o_underflow;
    logic        o_overflow;
    logic        o_zero;

    logic [43:0] out_pk;
    assign out_pk = {o_sign, o_exp, o_mant, o_tag, o_underflow, o_overflow, o_zero};

    int n_tests = 0;
    int n_fail  = 0;

    fp_norm_pipe #(
        .EXP_W  (8),
        .MANT_W (28),
        .TAG_W  (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .i_tag       (i_tag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sign      (o_sign),
        .o_exp       (o_exp),
        .o_mant      (o_mant),
        .o_tag       (o_tag),
        .o_underflow (o_underflow),
        .o_overflow  (o_overflow),
        .o_zero      (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic [7:0]  e_exp;
        logic [27:0] e_mant;
        logic        e_uf;
        logic        e_of;
        logic        e_zero;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                                input logic [7:0] ee, input logic [27:0] em,
                                input logic uf, input logic ovf, input logic z);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m;
        v.e_exp = ee; v.e_mant = em; v.e_uf = uf; v.e_of = ovf; v.e_zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input vec_t v, input logic [3:0] tag);
        i_valid = 1'b1;
        i_sign  = v.sign;
        i_exp   = v.exp;
        i_mant  = v.mant;
        i_tag   = tag;
    endtask

    // Send one vector into an idle pipe and check the 2-cycle latency and result.
    task automatic send_check(input int idx, input string name);
        vec_t v;
        logic [3:0] tag;
        v   = tbl[idx];
        tag = 4'(idx);
        @(negedge i_clk);
        drive(v, tag);
        chk({name, "_ready"}, 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk({name, "_lat1"}, 64'(o_valid), 64'd0);
        @(negedge i_clk);
        chk({name, "_lat2"}, 64'(o_valid), 64'd1);
        chk(name, 64'(out_pk),
            64'({v.sign, v.e_exp, v.e_mant, tag, v.e_uf, v.e_of, v.e_zero}));
    endtask

    initial begin
        int in_idx, out_idx, occ;
        bit saw_low, acc, cons;
        vec_t bp;

        tbl[0]  = mk(0, 8'h80, 28'h0400000, 8'h7C, 28'h4000000, 0, 0, 0);
        tbl[1]  = mk(0, 8'h80, 28'h8000001, 8'h81, 28'h4000001, 0, 0, 0);
        tbl[2]  = mk(0, 8'hFE, 28'h8000000, 8'hFF, 28'h0000000, 0, 1, 0);
        tbl[3]  = mk(1, 8'hFF, 28'h8000003, 8'hFF, 28'h0000000, 0, 1, 0);
        tbl[4]  = mk(0, 8'h03, 28'h0000100, 8'h00, 28'h0000400, 1, 0, 0);
        tbl[5]  = mk(0, 8'h04, 28'h0400000, 8'h00, 28'h2000000, 1, 0, 0);
        tbl[6]  = mk(1, 8'h55, 28'h0000000, 8'h00, 28'h0000000, 0, 0, 1);
        tbl[7]  = mk(0, 8'h00, 28'h0000010, 8'h00, 28'h0000010, 1, 0, 0);
        tbl[8]  = mk(0, 8'h05, 28'h0400000, 8'h01, 28'h4000000, 0, 0, 0);
        tbl[9]  = mk(1, 8'h80, 28'h4000000, 8'h80, 28'h4000000, 0, 0, 0);
        tbl[10] = mk(0, 8'h10, 28'hFFFFFFF, 8'h11, 28'h7FFFFFF, 0, 0, 0);
        tbl[11] = mk(0, 8'h20, 28'h0000123, 8'h0E, 28'h48C0000, 0, 0, 0);
        tbl[12] = mk(0, 8'h01, 28'h0000100, 8'h00, 28'h0000100, 1, 0, 0);

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_sign  = 1'b0;
        i_exp   = '0;
        i_mant  = '0;
        i_tag   = '0;

        #1;
        chk("reset_state", 64'({o_valid, out_pk, o_ready}), 64'({1'b0, 44'd0, 1'b1}));
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("idle_ready", 64'({o_valid, o_ready}), 64'b01);

        for (int i = 0; i < 13; i++)
            send_check(i, $sformatf("vec%0d", i));

        // Backpressure: 6 beats back-to-back, downstream stalls for cycles 3..6.
        bp = tbl[0];
        in_idx = 0; out_idx = 0; occ = 0; saw_low = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            i_ready = !(c >= 3 && c <= 6);
            if (in_idx < 6) drive(bp, in_idx[3:0]);
            else i_valid = 1'b0;
            #1;
            chk("bp_ready", 64'(o_ready), 64'(!(occ == 2 && !i_ready)));
            if (!o_ready) saw_low = 1;
            if (o_valid) begin
                if (out_idx < 6)
                    chk("bp_out", 64'(out_pk),
                        64'({1'b0, 8'h7C, 28'h4000000, out_idx[3:0], 3'b000}));
                else
                    chk("bp_extra_valid", 64'(o_valid), 64'd0);
            end
            acc  = i_valid && o_ready;
            cons = o_valid && i_ready;
            if (acc)  in_idx++;
            if (cons) out_idx++;
            occ = occ + int'(acc) - int'(cons);
        end
        chk("bp_count", 64'(out_idx), 64'd6);
        chk("bp_ready_dropped", 64'(saw_low), 64'd1);
        i_ready = 1'b1;

        // Reset with two beats in flight: outputs clear at once, beats are dropped.
        @(negedge i_clk);
        drive(tbl[1], 4'hA);
        @(negedge i_clk);
        drive(tbl[4], 4'hB);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("pre_reset_valid", 64'(o_valid), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({o_valid, out_pk, o_ready}), 64'({1'b0, 44'd0, 1'b1}));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            chk("dropped_after_reset", 64'(o_valid), 64'd0);
        end
        send_check(10, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
